// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch queue.
//   - default widths and queue depth
//   - FSM state encoding (LOAD/FETCH/FULL)
//   - queue entry layout {addr, data} at the default widths
package fetch_pkg;

    localparam int FETCH_ADDR_W = 16;
    localparam int FETCH_DATA_W = 16;
    localparam int FETCH_DEPTH  = 4;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FETCH = 2'd1,
        FULL  = 2'd2
    } fetch_state_e;

    // Address sits in the upper bits so a packed entry reads {addr, data}.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous DEPTH-entry FIFO used as the prefetch queue.
// Ports:
//   clk_i, rst_n_i        clock, synchronous active-low reset
//   flush_i               empties the queue next cycle (wins over push/pop)
//   push_i, wdata_i       write an entry (ignored when full)
//   pop_i                 drop the head entry (ignored when empty)
//   rdata_o               head entry (entry at the read pointer)
//   count_o               number of valid entries, 0..DEPTH
//   empty_o, full_o       occupancy flags
// Push and pop in the same cycle are both performed; count is unchanged.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic do_push;
    logic do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: nothing is read unless count says it is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_16bit.sv
// fetch_queue_16bit: instruction fetch stage behind the program counter.
// Loads a start address from pc_in, issues single-beat reads to instruction
// memory, buffers {addr, data} in a prefetch queue and hands words to the
// decoder. A redirect flushes everything and refetches from pc_in.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   pc_in, redirect       fetch start address / flush-and-reload strobe
//   mem_req, mem_addr     read request and its address (held until mem_ack)
//   mem_ack, mem_rdata    same-cycle accept with read data
//   instr_valid/_data/_addr, instr_ready   decoder handshake
//   busy                  low only in FETCH with an empty queue
//   dbg_state_o           current FSM state (LOAD/FETCH/FULL)
// Handshakes: a transfer happens on any rising edge where valid (mem_req /
// instr_valid) and the accepting side (mem_ack / instr_ready) are both high;
// the valid side does not depend combinationally on the accepting side.
module fetch_queue_16bit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              redirect,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic              instr_ready,
    output logic              busy,
    output logic [1:0]        dbg_state_o
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;

    entry_t                 push_entry;
    entry_t                 head_entry;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   pop;
    logic                   push_acc;

    assign pop      = instr_valid && instr_ready;
    // Data acked during a redirect belongs to the old stream and is dropped.
    assign push_acc = mem_req && mem_ack && !redirect;

    assign push_entry = '{addr: fetch_addr_q, data: mem_rdata};

    fetch_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_n_i (reset),
        .flush_i (redirect),
        .push_i  (push_acc),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head_entry),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= LOAD;
            fetch_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // Next-state and fetch address.
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        if (redirect) begin
            state_d = LOAD;
        end else begin
            unique case (state_q)
                LOAD: begin
                    state_d      = FETCH;
                    fetch_addr_d = pc_in;
                end
                FETCH: begin
                    // A pop in the same cycle frees a slot, so stay fetching.
                    if (fifo_full && !pop) state_d = FULL;
                    if (push_acc) fetch_addr_d = fetch_addr_q + 1'b1;
                end
                FULL: begin
                    if (pop) state_d = FETCH;
                end
                default: state_d = LOAD;
            endcase
        end
    end

    // Outputs.
    always_comb begin
        mem_req = (state_q == FETCH) && !fifo_full;
        busy    = !((state_q == FETCH) && fifo_empty);
    end

    assign mem_addr    = fetch_addr_q;
    assign instr_valid = !fifo_empty;
    // Head fields read as zero when nothing is queued.
    assign instr_data  = fifo_empty ? '0 : head_entry.data;
    assign instr_addr  = fifo_empty ? '0 : head_entry.addr;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_queue_16bit.sv
// Bench for fetch_queue_16bit. The reference model keeps the expected queue
// contents as {addr, data} words and an expected next fetch address; the
// monitor compares the decoder-side outputs against the queue head.
module tb_fetch_queue_16bit;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;

    // Clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] pc_in;
    logic          redirect;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic          instr_valid;
    logic [DW-1:0] instr_data;
    logic [AW-1:0] instr_addr;
    logic          instr_ready;
    logic          busy;
    logic [1:0]    dbg_state;

    fetch_queue_16bit dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .redirect    (redirect),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_data  (instr_data),
        .instr_addr  (instr_addr),
        .instr_ready (instr_ready),
        .busy        (busy),
        .dbg_state_o (dbg_state)
    );

    // Scoreboard / model state
    logic [AW+DW-1:0] exp_q[$];
    logic [AW-1:0]    model_addr;
    logic [AW+DW-1:0] push_val;
    bit               load_now;
    bit               after_reset;
    bit               flush_pend;
    bit               push_pend;
    bit               mon_on;
    int               wait_cnt;
    int               n_checks;
    int               n_pass;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // One clock cycle: update model with last cycle's events, check the
    // registered outputs, then drive this cycle's inputs.
    // ack_mode: 0 never, 1 always, 2 after 3 wait cycles, 3 random
    // ready_mode: 0 low, 1 high, 2 random
    task automatic step(input bit rst_n, input bit redir, input logic [AW-1:0] pc,
                        input int ack_mode, input int ready_mode);
        @(posedge clk);
        #1;
        if (flush_pend) exp_q.delete();
        else if (push_pend) exp_q.push_back(push_val);
        flush_pend = 0;
        push_pend  = 0;

        chk("mem_req", 32'(mem_req), 32'(!load_now && (exp_q.size() < DEPTH)));
        chk("busy", 32'(busy), 32'(load_now || (exp_q.size() != 0)));
        if (load_now) chk("state_load", 32'(dbg_state), 32'd0);
        if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(model_addr));
        if (after_reset) begin
            chk("rst_mem_addr", 32'(mem_addr), 32'd0);
            chk("rst_instr_data", 32'(instr_data), 32'd0);
            chk("rst_instr_addr", 32'(instr_addr), 32'd0);
        end

        reset     = rst_n;
        redirect  = redir;
        pc_in     = pc;
        mem_rdata = DW'($urandom);
        case (ready_mode)
            0:       instr_ready = 1'b0;
            1:       instr_ready = 1'b1;
            default: instr_ready = 1'($urandom_range(0, 1));
        endcase
        case (ack_mode)
            0:       mem_ack = 1'b0;
            1:       mem_ack = 1'b1;
            2:       mem_ack = (wait_cnt >= 3);
            default: mem_ack = 1'($urandom_range(0, 1));
        endcase
        if (mem_req && !mem_ack) wait_cnt++;
        else wait_cnt = 0;

        if (!rst_n) begin
            flush_pend  = 1;
            load_now    = 1;
            after_reset = 1;
            model_addr  = '0;
            wait_cnt    = 0;
        end else begin
            after_reset = 0;
            if (redir) begin
                flush_pend = 1;
                load_now   = 1;
            end else if (load_now) begin
                model_addr = pc;
                load_now   = 0;
            end else if (mem_req && mem_ack) begin
                push_pend  = 1;
                push_val   = {model_addr, mem_rdata};
                model_addr = model_addr + 1'b1;
            end
        end
    endtask

    // Monitor: decoder side of the queue.
    always @(negedge clk) begin
        if (mon_on) begin
            chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() != 0));
            if (instr_valid && exp_q.size() != 0) begin
                chk("instr_addr", 32'(instr_addr), 32'(exp_q[0][AW+DW-1:DW]));
                chk("instr_data", 32'(instr_data), 32'(exp_q[0][DW-1:0]));
                if (instr_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        mon_on      = 0;
        load_now    = 1;
        after_reset = 1;
        flush_pend  = 1;
        push_pend   = 0;
        push_val    = '0;
        model_addr  = '0;
        wait_cnt    = 0;
        reset       = 1'b0;
        redirect    = 1'b0;
        pc_in       = '0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        mon_on = 1;

        // Reset, then stream from 0x0100 with memory always ready.
        step(0, 0, 16'h0000, 1, 1);
        step(0, 0, 16'h0000, 1, 1);
        for (int i = 0; i < 12; i++) step(1, 0, (i == 0) ? 16'h0100 : AW'($urandom), 1, 1);

        // Decoder stalled: fill the queue, go FULL, release one pop.
        for (int i = 0; i < 10; i++) step(1, 0, AW'($urandom), 1, 0);
        step(1, 0, AW'($urandom), 1, 1);
        for (int i = 0; i < 5; i++) step(1, 0, AW'($urandom), 1, 0);
        for (int i = 0; i < 8; i++) step(1, 0, AW'($urandom), 1, 1);

        // Slow memory: ack after three wait cycles.
        for (int i = 0; i < 40; i++) step(1, 0, AW'($urandom), 2, 2);

        // Redirect to 0x2000 with three queued entries and an ack in flight.
        step(1, 1, 16'h0300, 1, 1);
        step(1, 0, 16'h0300, 1, 0);
        for (int i = 0; i < 3; i++) step(1, 0, AW'($urandom), 1, 0);
        step(1, 1, 16'h2000, 1, 0);
        step(1, 0, 16'h2000, 1, 1);
        for (int i = 0; i < 8; i++) step(1, 0, AW'($urandom), 1, 1);

        // Address wrap from 0xFFFE, including a redirect during LOAD.
        step(1, 1, 16'h1234, 1, 1);
        step(1, 1, 16'h5678, 1, 1);
        step(1, 0, 16'hFFFE, 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, AW'($urandom), 1, 0);
        for (int i = 0; i < 6; i++) step(1, 0, AW'($urandom), 1, 1);

        // Reset while a request is waiting for its ack.
        step(1, 1, 16'h0040, 0, 1);
        step(1, 0, 16'h0040, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, AW'($urandom), 0, 1);
        step(0, 0, AW'($urandom), 1, 1);
        step(1, 0, 16'h0500, 3, 2);
        for (int i = 0; i < 10; i++) step(1, 0, AW'($urandom), 3, 2);

        // Random traffic with occasional redirects and resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0), ($urandom_range(0, 49) == 0),
                 AW'($urandom), 3, 2);
        end

        step(1, 0, AW'($urandom), 0, 0);
        @(posedge clk);
        #1;
        mon_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_queue_16bit.md
Name: fetch_queue_16bit

Overview:
- Instruction fetch stage directly downstream of the 16-bit program counter.
- Takes the counter's current value as a fetch start address and issues single-beat reads to instruction memory.
- Buffers returned instruction words with their addresses in a small prefetch queue.
- Presents them to the decoder over a valid/ready handshake; a redirect (counter load) flushes the queue and restarts fetching from the new PC.

Parameters:
- ADDR_W, 16, width of PC / fetch address.
- DATA_W, 16, instruction word width.
- DEPTH, 4, prefetch queue entries (power of two, ≥2).

Ports:
- clk  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-low reset (reset==0 sampled at posedge clears state).
- pc_in  input  ADDR_W  current program counter value (counter dataout).
- redirect  input  1  counter is being loaded with a new target; flush and refetch from pc_in.
- mem_req  output  1  read request valid.
- mem_addr  output  ADDR_W  read address; stable while mem_req high and mem_ack low.
- mem_ack  input  1  memory accepts request; mem_rdata valid this same cycle.
- mem_rdata  input  DATA_W  instruction word returned with mem_ack.
- instr_valid  output  1  queue head valid.
- instr_data  output  DATA_W  head instruction word.
- instr_addr  output  ADDR_W  address of head instruction.
- instr_ready  input  1  decoder consumes head when instr_valid & instr_ready.
- busy  output  1  high in any state other than FETCH with an empty queue.

Behaviour:
- Reset (reset==0 at posedge): state=LOAD, count=0, rd/wr pointers=0, fetch_addr=0; outputs mem_req=0, mem_addr=0, instr_valid=0, instr_data=0, instr_addr=0, busy=1.
- States:
  - LOAD: fetch_addr<=pc_in, go to FETCH; mem_req=0.
  - FETCH: mem_req = (count<DEPTH); otherwise go to FULL.
  - FULL: mem_req=0; return to FETCH the cycle after any pop.
- mem_addr = fetch_addr (registered).
- Push on mem_req & mem_ack: write {fetch_addr, mem_rdata} at wr_ptr; fetch_addr<=fetch_addr+1, mod 2^ADDR_W (0xFFFF wraps to 0x0000).
- One request in flight at most; read latency from first mem_req cycle is ≥1 cycle; mem_req holds until ack.
- Data enters the queue at posedge of the ack cycle; earliest instr_valid is the next cycle.
- Pop on instr_valid & instr_ready; instr_valid = (count!=0); head outputs driven from rd_ptr entry.
- Simultaneous push and pop: both happen, count unchanged; permitted whenever mem_req was asserted (count<DEPTH at cycle start).
- FULL: no request issued even if a pop happens the same cycle; the request resumes next cycle.
- Redirect (priority over everything except reset):
  - Next cycle: count=0, pointers=0, instr_valid=0, state=LOAD.
  - Any mem_ack data in the redirect cycle is discarded.
  - Any pop in that cycle is still considered consumed by the decoder.
  - Asserting mem_req in the redirect cycle is allowed; it is dropped after the cycle.
- Redirect during LOAD: re-enters LOAD and samples pc_in again.
- Reset mid-request: mem_req drops next cycle; the memory must tolerate request withdrawal on reset/redirect.
- pc_in is ignored except in LOAD.

Decomposition:
- Shared package (fetch_pkg):
  - State encoding constants LOAD=2'd0, FETCH=2'd1, FULL=2'd2.
  - Default widths ADDR_W=16, DATA_W=16.
  - Queue entry struct {addr, data}.
- One sub-module: fetch_fifo (synchronous DEPTH-entry FIFO, push/pop/flush, count, same-cycle push+pop, synchronous active-low reset).
- FSM and address logic live in the top.

Test Plan:
- Reset then release with pc_in=0x0100, mem_ack tied high, instr_ready=1 → mem_addr 0x0100, 0x0101, 0x0102… on consecutive cycles; instr_addr/instr_data stream in order, first instr_valid 2 cycles after LOAD exit.
- instr_ready=0, mem_ack=1 → exactly 4 pushes (0x0100–0x0103), then state FULL, mem_req=0; one pop → mem_req reasserts next cycle for 0x0104.
- mem_ack delayed 3 cycles per request → mem_addr stable during wait, no duplicate entries, queue order preserved.
- Redirect with pc_in=0x2000 while queue holds 3 entries and mem_ack high same cycle → next cycle instr_valid=0, acked word dropped, following fetch at 0x2000.
- fetch start 0xFFFE → entries 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Assert reset=0 mid-wait with mem_req high → next cycle all outputs at reset values, count=0, then restart from pc_in in LOAD.
